fetch_prefetch_unit: RTL and testbench
======================================

Name: fetch_prefetch_unit

Overview:
- Parametrised instruction-fetch front end for the CPU. Replaces the single clocked program counter and its next-address logic.
- Owns the fetch PC and drives a request/acknowledge handshake to memory port A, which supports variable latency.
- Buffers returned instructions, tagged with their addresses, in a FIFO of depth DEPTH in front of the control logic.
- Applies jump/branch redirects, including flushing the buffer and discarding in-flight fetches.

Parameters:
- ADDR_WIDTH, 15, fetch address width; PC arithmetic wraps mod 2^ADDR_WIDTH.
- DATA_WIDTH, 16, instruction width.
- DEPTH, 4, prefetch FIFO entries (power of two, >= 2).
- DISP_WIDTH, 8, signed branch displacement width.
- RESET_PC, 0, fetch address loaded at reset.

Ports:
- clock  in  1  system clock; all state changes on rising edge.
- reset  in  1  synchronous, active-low reset (asserted when 0, sampled on rising edge of clock).
- fetch_enable  in  1  permits new memory requests (the former pcEnabled).
- mem_req  out  1  fetch request to memory port A.
- mem_addr  out  ADDR_WIDTH  fetch address; stable while mem_req is high and unacknowledged.
- mem_ack  in  1  memory completes the current request this cycle; valid only while mem_req=1.
- mem_rdata  in  DATA_WIDTH  instruction word, valid when mem_ack=1.
- instr_valid  out  1  FIFO head is valid.
- instr  out  DATA_WIDTH  FIFO head instruction.
- instr_pc  out  ADDR_WIDTH  address of the FIFO head instruction.
- instr_ready  in  1  consumer pops the head when instr_valid && instr_ready.
- redirect_jump  in  1  jump; target = jump_addr.
- jump_addr  in  ADDR_WIDTH  absolute jump target.
- redirect_branch  in  1  taken branch; target = branch_base + sign-extended branch_disp, mod 2^ADDR_WIDTH.
- branch_base  in  ADDR_WIDTH  base address for the branch.
- branch_disp  in  DISP_WIDTH  two's-complement displacement.
- occupancy  out  clog2(DEPTH)+1  current FIFO entry count.

Behaviour:
- Reset, while reset=0 at an edge:
  - fetch_pc=RESET_PC; FIFO emptied; occupancy=0.
  - mem_req=0, instr_valid=0, state=IDLE.
  - instr and instr_pc are don't-care while instr_valid=0.
  - A reset mid-transaction abandons the transaction. The memory must tolerate req dropping.
- States:
  - IDLE: mem_req=0.
  - REQ: mem_req=1, mem_addr=fetch_pc.
  - DISCARD: mem_req=1, mem_addr=address of the stale request; its data will be dropped.
- Issue rule: a request is started or continued for cycle t+1 only if fetch_enable=1 and (occupancy after cycle t's push/pop) < DEPTH. This reserves a slot for the response, so a push never meets a full FIFO.
- IDLE -> REQ when the issue rule holds. mem_addr=fetch_pc.
- REQ with mem_ack=1 and no redirect:
  - Push {fetch_pc, mem_rdata}; fetch_pc increments, wrapping from 2^ADDR_WIDTH-1 to 0.
  - Stay in REQ at the new address if the issue rule holds, otherwise go to IDLE.
  - Zero-wait memory therefore sustains one fetch per cycle.
- REQ with mem_ack=0: hold mem_req and mem_addr unchanged; fetch_enable falling does not withdraw an issued request.
- Redirect, on any cycle where redirect_jump or redirect_branch is 1:
  - Jump has priority when both are asserted.
  - FIFO is flushed at the edge (occupancy=0, instr_valid=0 next cycle); a same-cycle pop is subsumed.
  - fetch_pc=target.
  - If in REQ with mem_ack=0: go to DISCARD.
  - If in REQ with mem_ack=1: data dropped, no push; go to REQ at target if the issue rule holds, else IDLE.
  - If IDLE: go to REQ at target if the issue rule holds.
- DISCARD:
  - Hold the stale address until mem_ack.
  - On ack, drop the data and go to REQ at fetch_pc (or IDLE if the issue rule fails).
  - A further redirect while in DISCARD just updates fetch_pc and stays in DISCARD.
- FIFO:
  - Push and pop in the same cycle leave occupancy unchanged.
  - Pop when empty is ignored.
  - instr_valid = (occupancy != 0), registered from the FIFO state.
  - Head data is stable while instr_valid && !instr_ready.
- Latency:
  - Request issued the cycle after reset release, provided fetch_enable=1.
  - With ack in the same cycle as the request, instr_valid rises the following cycle.
  - First instruction is visible 2 cycles after reset release.

Test Plan:
- Reset=0 for 2 cycles, then 1; fetch_enable=1; zero-wait memory returning 0xA000+addr; instr_ready=1 -> mem_addr sequence 0,1,2,...; instr_valid from cycle 2; instr/instr_pc = 0xA000/0, 0xA001/1, ... one per cycle.
- instr_ready=0, zero-wait memory -> exactly 4 pushes; mem_req drops; occupancy=4. Then instr_ready=1 for one cycle -> occupancy=3 and one new request issued at address 4.
- 3-cycle memory latency, redirect_jump=1, jump_addr=0x100 on the second wait cycle -> stale ack data not pushed; next mem_addr=0x100; first instr_pc=0x100.
- redirect_branch with branch_base=0x0005, branch_disp=0xFE (-2) -> target 0x0003; with branch_base=0x7FFF, disp=0x01 -> target 0x0000 (wrap).
- redirect_jump and redirect_branch together plus a same-cycle mem_ack and pop -> jump target used; FIFO empty next cycle; acked data dropped.
- reset=0 asserted while in DISCARD with 2 FIFO entries -> next cycle mem_req=0, occupancy=0; after release, fetching restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_prefetch_unit.sv
// Instruction-fetch front end: owns the fetch PC, drives a variable-latency
// memory handshake and buffers address-tagged instructions in a small FIFO.
module fetch_prefetch_unit #(
  parameter int                    ADDR_WIDTH = 15,
  parameter int                    DATA_WIDTH = 16,
  parameter int                    DEPTH      = 4,
  parameter int                    DISP_WIDTH = 8,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          fetch_enable,
  output logic                          mem_req,
  output logic [ADDR_WIDTH-1:0]         mem_addr,
  input  logic                          mem_ack,
  input  logic [DATA_WIDTH-1:0]         mem_rdata,
  output logic                          instr_valid,
  output logic [DATA_WIDTH-1:0]         instr,
  output logic [ADDR_WIDTH-1:0]         instr_pc,
  input  logic                          instr_ready,
  input  logic                          redirect_jump,
  input  logic [ADDR_WIDTH-1:0]         jump_addr,
  input  logic                          redirect_branch,
  input  logic [ADDR_WIDTH-1:0]         branch_base,
  input  logic [DISP_WIDTH-1:0]         branch_disp,
  output logic [$clog2(DEPTH):0]        occupancy
);

  localparam int PTR_W   = $clog2(DEPTH);
  localparam int OCC_W   = PTR_W + 1;
  localparam int ENTRY_W = ADDR_WIDTH + DATA_WIDTH;

  typedef enum logic [1:0] {IDLE, REQ, DISCARD} state_t;

  state_t                  state_q;
  logic                    mem_req_q;
  logic [ADDR_WIDTH-1:0]   fetch_pc_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [OCC_W-1:0]        occ_q;
  logic [OCC_W-1:0]        occ_d;
  logic [PTR_W-1:0]        rd_ptr_q;
  logic [PTR_W-1:0]        wr_ptr_q;
  logic                    valid_q;
  logic [ENTRY_W-1:0]      mem_q [DEPTH];
  logic [ENTRY_W-1:0]      head;

  logic                    redirect;
  logic [ADDR_WIDTH-1:0]   target;
  logic [ADDR_WIDTH-1:0]   next_pc;
  logic [ADDR_WIDTH-1:0]   pc_inc;
  logic                    push;
  logic                    pop;
  logic                    issue;

  always_comb begin
    redirect = redirect_jump | redirect_branch;
    target   = redirect_jump ? jump_addr
             : branch_base + {{(ADDR_WIDTH-DISP_WIDTH){branch_disp[DISP_WIDTH-1]}}, branch_disp};
    next_pc  = redirect ? target : fetch_pc_q;
    pc_inc   = fetch_pc_q + ADDR_WIDTH'(1);
    push     = (state_q == REQ) && mem_ack && !redirect;
    // A redirect flushes the FIFO, so a same-cycle pop has nothing left to remove.
    pop      = valid_q && instr_ready && !redirect;
    occ_d    = redirect ? '0 : occ_q + OCC_W'(push) - OCC_W'(pop);
    // Only issue when the response is guaranteed a free slot.
    issue    = fetch_enable && (occ_d < OCC_W'(DEPTH));
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q    <= IDLE;
      mem_req_q  <= 1'b0;
      fetch_pc_q <= RESET_PC;
      addr_q     <= RESET_PC;
    end else begin
      case (state_q)
        IDLE: begin
          fetch_pc_q <= next_pc;
          if (issue) begin
            state_q   <= REQ;
            mem_req_q <= 1'b1;
            addr_q    <= next_pc;
          end
        end
        REQ: begin
          if (redirect) begin
            fetch_pc_q <= target;
            if (!mem_ack) begin
              state_q <= DISCARD;
            end else if (issue) begin
              addr_q <= target;
            end else begin
              state_q   <= IDLE;
              mem_req_q <= 1'b0;
            end
          end else if (mem_ack) begin
            fetch_pc_q <= pc_inc;
            if (issue) begin
              addr_q <= pc_inc;
            end else begin
              state_q   <= IDLE;
              mem_req_q <= 1'b0;
            end
          end
        end
        DISCARD: begin
          // The stale address stays on the bus until memory finishes with it.
          fetch_pc_q <= next_pc;
          if (mem_ack) begin
            if (issue) begin
              state_q <= REQ;
              addr_q  <= next_pc;
            end else begin
              state_q   <= IDLE;
              mem_req_q <= 1'b0;
            end
          end
        end
        default: begin
          state_q   <= IDLE;
          mem_req_q <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!reset || redirect) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      occ_q    <= '0;
      valid_q  <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      occ_q   <= occ_d;
      valid_q <= (occ_d != '0);
    end
  end

  always_ff @(posedge clock) begin
    if (push) mem_q[wr_ptr_q] <= {fetch_pc_q, mem_rdata};
  end

  assign head        = mem_q[rd_ptr_q];
  assign instr       = head[DATA_WIDTH-1:0];
  assign instr_pc    = head[ENTRY_W-1:DATA_WIDTH];
  assign instr_valid = valid_q;
  assign occupancy   = occ_q;
  assign mem_req     = mem_req_q;
  assign mem_addr    = addr_q;

endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// Directed bench for fetch_prefetch_unit: memory model answers 0xA000+addr
// after a programmable number of wait cycles.
module tb_fetch_prefetch_unit;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        fetch_enable = 1'b1;
  logic        mem_req;
  logic [14:0] mem_addr;
  logic        mem_ack = 1'b0;
  logic [15:0] mem_rdata = '0;
  logic        instr_valid;
  logic [15:0] instr;
  logic [14:0] instr_pc;
  logic        instr_ready = 1'b1;
  logic        redirect_jump = 1'b0;
  logic [14:0] jump_addr = '0;
  logic        redirect_branch = 1'b0;
  logic [14:0] branch_base = '0;
  logic [7:0]  branch_disp = '0;
  logic [2:0]  occupancy;

  int total = 0;
  int bad   = 0;
  int lat   = 0;
  int cnt   = 0;

  fetch_prefetch_unit dut (
    .clock(clock), .reset(reset), .fetch_enable(fetch_enable),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc), .instr_ready(instr_ready),
    .redirect_jump(redirect_jump), .jump_addr(jump_addr),
    .redirect_branch(redirect_branch), .branch_base(branch_base), .branch_disp(branch_disp),
    .occupancy(occupancy)
  );

  always #5 clock = ~clock;

  // Advance one cycle, then set up this cycle's memory response.
  task automatic tick();
    @(posedge clock);
    #1;
    if (mem_req) begin
      if (cnt >= lat) begin
        mem_ack   = 1'b1;
        mem_rdata = 16'hA000 + 16'(mem_addr);
        cnt       = 0;
      end else begin
        mem_ack = 1'b0;
        cnt     = cnt + 1;
      end
    end else begin
      mem_ack = 1'b0;
      cnt     = 0;
    end
  endtask

  task automatic do_reset();
    reset           = 1'b0;
    redirect_jump   = 1'b0;
    redirect_branch = 1'b0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    lat = 0; instr_ready = 1'b1;
    do_reset();
    total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL reset_req got %b want 0", mem_req); end
    total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got %b want 0", instr_valid); end
    total++; if (occupancy !== 3'd0) begin bad++; $display("FAIL reset_occ got %0d want 0", occupancy); end
    tick();
    total++; if (mem_req !== 1'b1 || mem_addr !== 15'd0) begin bad++; $display("FAIL first_req got req=%b addr=%h want 1/0000", mem_req, mem_addr); end
    $display("reset: req=%b addr=%h", mem_req, mem_addr);
  endtask

  task automatic test_stream();
    for (int i = 0; i < 6; i++) begin
      tick();
      total++;
      if (instr_valid !== 1'b1 || instr !== 16'hA000 + 16'(i) || instr_pc !== 15'(i) || mem_addr !== 15'(i + 1)) begin
        bad++;
        $display("FAIL stream%0d got v=%b instr=%h pc=%h addr=%h want 1/%h/%h/%h",
                 i, instr_valid, instr, instr_pc, mem_addr, 16'hA000 + 16'(i), 15'(i), 15'(i + 1));
      end
      $display("stream: pc=%h instr=%h", instr_pc, instr);
    end
  endtask

  task automatic test_backpressure();
    lat = 0; instr_ready = 1'b0;
    do_reset();
    for (int i = 0; i < 6; i++) tick();
    total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL full_req got %b want 0", mem_req); end
    total++; if (occupancy !== 3'd4) begin bad++; $display("FAIL full_occ got %0d want 4", occupancy); end
    total++; if (instr_pc !== 15'd0 || instr !== 16'hA000) begin bad++; $display("FAIL full_head got %h/%h want 0000/a000", instr_pc, instr); end
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;
    total++; if (occupancy !== 3'd3) begin bad++; $display("FAIL pop_occ got %0d want 3", occupancy); end
    total++; if (mem_req !== 1'b1 || mem_addr !== 15'd4) begin bad++; $display("FAIL refill_req got %b/%h want 1/0004", mem_req, mem_addr); end
    total++; if (instr_pc !== 15'd1) begin bad++; $display("FAIL pop_head got %h want 0001", instr_pc); end
    tick();
    total++; if (occupancy !== 3'd4 || mem_req !== 1'b0) begin bad++; $display("FAIL refull got occ=%0d req=%b want 4/0", occupancy, mem_req); end
    $display("backpressure: occ=%0d req=%b", occupancy, mem_req);
  endtask

  task automatic test_jump_discard();
    bit seen;
    lat = 3; instr_ready = 1'b1;
    do_reset();
    tick();
    tick();
    redirect_jump = 1'b1; jump_addr = 15'h100;
    tick();
    redirect_jump = 1'b0;
    total++; if (mem_req !== 1'b1 || mem_addr !== 15'd0) begin bad++; $display("FAIL discard_hold got %b/%h want 1/0000", mem_req, mem_addr); end
    tick();
    tick();
    total++; if (mem_addr !== 15'h100 || occupancy !== 3'd0 || instr_valid !== 1'b0) begin
      bad++; $display("FAIL after_discard got addr=%h occ=%0d v=%b want 0100/0/0", mem_addr, occupancy, instr_valid);
    end
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      tick();
      seen = instr_valid;
    end
    total++; if (!seen || instr_pc !== 15'h100 || instr !== 16'hA100) begin
      bad++; $display("FAIL jump_first got v=%b pc=%h instr=%h want 1/0100/a100", seen, instr_pc, instr);
    end
    $display("jump: pc=%h instr=%h", instr_pc, instr);
  endtask

  task automatic test_branch();
    lat = 0; instr_ready = 1'b1;
    do_reset();
    tick();
    tick();
    redirect_branch = 1'b1; branch_base = 15'h0005; branch_disp = 8'hFE;
    tick();
    redirect_branch = 1'b0;
    total++; if (mem_addr !== 15'h0003 || instr_valid !== 1'b0 || occupancy !== 3'd0) begin
      bad++; $display("FAIL branch_neg got addr=%h v=%b occ=%0d want 0003/0/0", mem_addr, instr_valid, occupancy);
    end
    tick();
    total++; if (instr_pc !== 15'h0003 || instr !== 16'hA003) begin bad++; $display("FAIL branch_neg_head got %h/%h want 0003/a003", instr_pc, instr); end
    redirect_branch = 1'b1; branch_base = 15'h7FFF; branch_disp = 8'h01;
    tick();
    redirect_branch = 1'b0;
    total++; if (mem_addr !== 15'h0000 || instr_valid !== 1'b0) begin bad++; $display("FAIL branch_wrap got addr=%h v=%b want 0000/0", mem_addr, instr_valid); end
    tick();
    total++; if (instr_pc !== 15'h0000 || instr !== 16'hA000) begin bad++; $display("FAIL branch_wrap_head got %h/%h want 0000/a000", instr_pc, instr); end
    redirect_jump = 1'b1; jump_addr = 15'h7FFF;
    tick();
    redirect_jump = 1'b0;
    tick();
    total++; if (instr_pc !== 15'h7FFF || mem_addr !== 15'h0000) begin bad++; $display("FAIL pc_wrap got pc=%h addr=%h want 7fff/0000", instr_pc, mem_addr); end
    $display("branch: pc=%h next=%h", instr_pc, mem_addr);
  endtask

  task automatic test_both_redirects();
    lat = 0; instr_ready = 1'b1;
    do_reset();
    tick();
    tick();
    redirect_jump = 1'b1; jump_addr = 15'h0040;
    redirect_branch = 1'b1; branch_base = 15'h0010; branch_disp = 8'h02;
    tick();
    redirect_jump = 1'b0; redirect_branch = 1'b0;
    total++; if (mem_addr !== 15'h0040 || instr_valid !== 1'b0 || occupancy !== 3'd0) begin
      bad++; $display("FAIL both_redir got addr=%h v=%b occ=%0d want 0040/0/0", mem_addr, instr_valid, occupancy);
    end
    tick();
    total++; if (instr_pc !== 15'h0040 || instr !== 16'hA040 || occupancy !== 3'd1) begin
      bad++; $display("FAIL both_head got %h/%h occ=%0d want 0040/a040/1", instr_pc, instr, occupancy);
    end
    $display("both: pc=%h instr=%h", instr_pc, instr);
  endtask

  task automatic test_reset_midflight();
    lat = 0; instr_ready = 1'b0;
    do_reset();
    tick();
    tick();
    lat = 3;
    tick();
    total++; if (occupancy !== 3'd2 || mem_req !== 1'b1 || mem_ack !== 1'b0) begin
      bad++; $display("FAIL mid_setup got occ=%0d req=%b ack=%b want 2/1/0", occupancy, mem_req, mem_ack);
    end
    reset = 1'b0;
    tick();
    total++; if (mem_req !== 1'b0 || occupancy !== 3'd0 || instr_valid !== 1'b0) begin
      bad++; $display("FAIL mid_reset got req=%b occ=%0d v=%b want 0/0/0", mem_req, occupancy, instr_valid);
    end
    reset = 1'b1; instr_ready = 1'b1;
    tick();
    redirect_jump = 1'b1; jump_addr = 15'h0020;
    tick();
    redirect_jump = 1'b0;
    reset = 1'b0;
    total++; if (mem_req !== 1'b1 || mem_addr !== 15'd0) begin bad++; $display("FAIL in_discard got %b/%h want 1/0000", mem_req, mem_addr); end
    tick();
    total++; if (mem_req !== 1'b0 || occupancy !== 3'd0) begin bad++; $display("FAIL discard_reset got req=%b occ=%0d want 0/0", mem_req, occupancy); end
    reset = 1'b1; lat = 0;
    tick();
    total++; if (mem_req !== 1'b1 || mem_addr !== 15'd0) begin bad++; $display("FAIL restart got %b/%h want 1/0000", mem_req, mem_addr); end
    tick();
    total++; if (instr_valid !== 1'b1 || instr_pc !== 15'd0) begin bad++; $display("FAIL restart_head got v=%b pc=%h want 1/0000", instr_valid, instr_pc); end
    $display("midflight reset: restart pc=%h", instr_pc);
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_jump_discard();
    test_branch();
    test_both_redirects();
    test_reset_midflight();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
